// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and multiplier-state definitions for the alu_pipe datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  // Bit positions inside the {N,Z,C,V} flags vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Holds its product in DONE until the consumer acknowledges it.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             hi_nz,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mul_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Next-state and datapath update for the shift-add sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_BUSY;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
        end else begin
          state_d  = MUL_IDLE;
        end
      end
      MUL_BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = MUL_DONE;
        end else begin
          state_d = MUL_BUSY;
        end
      end
      MUL_DONE: begin
        if (ack) begin
          state_d = MUL_IDLE;
        end else begin
          state_d = MUL_DONE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Multiplier state register; reset drops any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy  = (state_q != MUL_IDLE);
  assign done  = (state_q == MUL_DONE);
  assign lo    = acc_q[WIDTH-1:0];
  assign hi_nz = |acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and a one-entry output register.
// Define ALU_PIPE_MUL_EN to build the multi-cycle unsigned multiplier for op 7.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             out_err
);

  localparam int SHW = $clog2(WIDTH);

  op_e              op_s;
  logic             busy_s, out_free_s, accept_s, load_s;
  logic [WIDTH:0]   add_s, sub_s, sll_s;
  logic [WIDTH-1:0] alu_res_s, ld_res_s;
  logic             alu_c_s, alu_v_s, alu_err_s;
  logic             ld_c_s, ld_v_s, ld_err_s;
  logic [3:0]       ld_flags_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_err_q, out_err_d;

  assign op_s       = op_e'(op);
  assign out_free_s = !out_valid_q || out_ready;
  assign in_ready   = !busy_s && out_free_s;
  assign accept_s   = in_valid && in_ready;

  // Carry/borrow/shift-out land in the extra top bit.
  assign add_s = {1'b0, src_a} + {1'b0, src_b};
  assign sub_s = {1'b0, src_a} - {1'b0, src_b};
  assign sll_s = {1'b0, src_a} << src_b[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
  logic             mul_start_s, mul_ack_s, mul_done_s, mul_hi_nz_s;
  logic [WIDTH-1:0] mul_lo_s;

  assign mul_start_s = accept_s && (op_s == OP_MUL);
  assign mul_ack_s   = mul_done_s && out_free_s;
  assign load_s      = (accept_s && (op_s != OP_MUL)) || mul_ack_s;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start_s),
    .a     (src_a),
    .b     (src_b),
    .ack   (mul_ack_s),
    .busy  (busy_s),
    .done  (mul_done_s),
    .hi_nz (mul_hi_nz_s),
    .lo    (mul_lo_s)
  );
`else
  assign busy_s = 1'b0;
  assign load_s = accept_s;
`endif

  // Single-cycle op decode.
  always_comb begin
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        alu_res_s = add_s[WIDTH-1:0];
        alu_c_s   = add_s[WIDTH];
        alu_v_s   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_s[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s[WIDTH-1:0];
        alu_c_s   = sub_s[WIDTH];
        alu_v_s   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_s[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_AND: alu_res_s = src_a & src_b;
      OP_OR:  alu_res_s = src_a | src_b;
      OP_XOR: alu_res_s = src_a ^ src_b;
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLL: begin
        alu_res_s = sll_s[WIDTH-1:0];
        alu_c_s   = sll_s[WIDTH];
      end
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: alu_res_s = '0;
`else
      OP_MUL: alu_err_s = 1'b1;
`endif
      default: alu_res_s = '0;
    endcase
  end

  // Select what the output register loads; a finished product takes priority.
  always_comb begin
    ld_res_s = alu_res_s;
    ld_c_s   = alu_c_s;
    ld_v_s   = alu_v_s;
    ld_err_s = alu_err_s;
`ifdef ALU_PIPE_MUL_EN
    if (mul_done_s) begin
      ld_res_s = mul_lo_s;
      ld_c_s   = mul_hi_nz_s;
      ld_v_s   = 1'b0;
      ld_err_s = 1'b0;
    end else begin
      ld_res_s = alu_res_s;
    end
`endif
    ld_flags_s         = 4'b0000;
    ld_flags_s[FLAG_N] = ld_res_s[WIDTH-1];
    ld_flags_s[FLAG_Z] = (ld_res_s == '0);
    ld_flags_s[FLAG_C] = ld_c_s;
    ld_flags_s[FLAG_V] = ld_v_s;
  end

  // Output register: load on refill, drop valid on drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_err_d   = out_err_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      result_d    = ld_res_s;
      flags_d     = ld_flags_s;
      out_err_d   = ld_err_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign out_err   = out_err_q;

endmodule
